hazard_sched: RTL and testbench
===============================

Name: hazard_sched

Overview:
- Pipeline hazard scheduler for the 5-stage LEGv8 core.
- Compares the instruction in ID (older) against the instruction in IF (younger) every cycle.
- Sequences load-use stalls (freeze PC and IF/ID, bubble into ID/EX) and branch squashes (NOP into IF/ID) for a parameterised number of cycles.
- Keeps saturating hazard counters for performance debug.

Parameters:
- LOAD_STALL_CYC, 1, cycles PC/IF/ID stay frozen after a load-use hit (1..3).
- BR_FLUSH_CYC, 1, consecutive fetch slots squashed after a branch reaches ID (1..3).
- CNT_W, 16, width of each saturating event counter.

Ports:
- clk  input  1  core clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- id_instr  input  32  instruction currently in ID.
- if_instr  input  32  instruction currently in IF.
- ext_stall  input  1  external freeze (data memory busy).
- pc_en  output  1  PC register write enable.
- ifid_en  output  1  IF/ID register write enable.
- ifid_flush  output  1  load 32'h00000000 into IF/ID.
- idex_bubble  output  1  load 32'h00000000 into ID/EX.
- busy  output  1  state != RUN.
- load_stalls  output  CNT_W  count of load-use events, saturating.
- br_flushes  output  CNT_W  count of branch events, saturating.

Behaviour:
- Classification (combinational, in sub-module):
  - load: instr[31:21]==11111000010 (LDUR).
  - branch: instr[31:21] matches ???101????? (B, BL, CBZ, CBNZ, B.cond).
  - Source regs of the younger instruction:
    - R-type: Rn[9:5], Rm[20:16].
    - D-type: Rn[9:5]; STUR also Rt[4:0].
    - CB-type: Rt[4:0].
    - B/BL: none.
- Load-use hit: id_instr is load, its Rt[4:0] equals any valid source reg of if_instr, and Rt != 31 (XZR never hazards).
- Reset values: state=RUN, cnt=0, counters=0. Outputs during reset: pc_en=1, ifid_en=1, ifid_flush=0, idex_bubble=0, busy=0.
- State machine, registered state, down-counter cnt[1:0]:
  - RUN:
    - Outputs: pc_en=1, ifid_en=1, flush=0, bubble=0.
    - On load-use hit: go to LOAD_STALL with cnt=LOAD_STALL_CYC-1, and assert pc_en=0, ifid_en=0, idex_bubble=1 in that same cycle (combinational).
    - Else if id_instr is branch: go to BR_FLUSH with cnt=BR_FLUSH_CYC-1, and assert ifid_flush=1 in that same cycle.
    - Load and branch cannot both be true for one id_instr; load-use has priority by construction.
  - LOAD_STALL:
    - Outputs: pc_en=0, ifid_en=0, idex_bubble=1.
    - Return to RUN when cnt==0; else decrement cnt.
    - Detection is disabled in this state; IF/ID is frozen, so it re-evaluates in RUN.
  - BR_FLUSH:
    - Outputs: ifid_flush=1, pc_en=1.
    - Return to RUN when cnt==0; else decrement cnt.
    - A branch squashed into the flushed slot is not re-detected.
- ext_stall=1 overrides all other controls:
  - Outputs: pc_en=0, ifid_en=0, ifid_flush=0, idex_bubble=0.
  - State, cnt and counters hold; no new detection.
  - Resumes exactly where it left off on deassertion.
- Total stall/flush length therefore equals LOAD_STALL_CYC or BR_FLUSH_CYC cycles, counting the detection cycle.
- Counters:
  - Increment by 1 on the detection cycle only, i.e. on the RUN→LOAD_STALL or RUN→BR_FLUSH transition.
  - Saturate at all-ones; never wrap.
- busy is registered from state; it is 0 in the detection cycle and 1 in the following cycles of the event.
- Reset asserted mid-stall: immediate return to RUN with cnt=0; counters cleared.

Decomposition:
- Package cpu_pkg holds:
  - Opcode constants: OP_LDUR, OP_STUR, branch wildcard mask, R/D/CB format masks.
  - typedef enum logic [1:0] {RUN, LOAD_STALL, BR_FLUSH} hz_state_t.
  - localparam XZR = 5'd31.
- Sub-module hazard_decode (combinational): instr in → is_load, is_branch, src_a/src_b (5b each) plus valid bits, rt.
  - Instantiated twice: for id_instr and for if_instr.

Test Plan:
- Load-use via Rn: id=0xF8400041 (LDUR X1,[X2]), if=0x8B040023 (ADD X3,X1,X4), defaults → detection cycle pc_en=0, ifid_en=0, idex_bubble=1; next cycle back in RUN (busy=1 for one cycle); load_stalls=1.
- No hazard on XZR: id=0xF840005F (LDUR XZR), if=0x8B1F03E3 (reads X31) → no stall; counter stays 0.
- Branch: id=0x14000004 (B #4), BR_FLUSH_CYC=2 → ifid_flush=1 for 2 consecutive cycles, pc_en=1 throughout; br_flushes=1.
- Load then dependent CBZ: id=0xF8400041, if=0xB4000021 (CBZ X1), LOAD_STALL_CYC=2 → 2 stall cycles; CBZ then moves to ID → 1-cycle flush; both counters=1.
- ext_stall asserted in the 2nd LOAD_STALL cycle for 3 cycles → all controls 0 during the freeze, state held; the remaining stall cycle completes after release.
- Reset asserted in BR_FLUSH → outputs return to reset values immediately, with no clock edge needed; counters=0. Also force load_stalls to 0xFFFF and trigger a load-use hit → value stays 0xFFFF.

Source files
------------

// File: rtl/cpu_pkg.sv
// ============================================================================
// Module      : cpu_pkg
// Description : Shared LEGv8 opcode constants and hazard-scheduler state type.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

    // Full 11-bit opcodes (instr[31:21])
    localparam logic [10:0] OP_LDUR   = 11'b111_1100_0010;
    localparam logic [10:0] OP_STUR   = 11'b111_1100_0000;

    // Wildcard classes as mask/match pairs on instr[31:21]
    localparam logic [10:0] BR_MASK   = 11'h0E0;   // instr[28:26] == 3'b101
    localparam logic [10:0] BR_MATCH  = 11'h0A0;
    localparam logic [10:0] R_MASK    = 11'h070;   // instr[27:25] == 3'b101
    localparam logic [10:0] R_MATCH   = 11'h050;
    localparam logic [10:0] D_MASK    = 11'h1F8;   // instr[29:24] == 6'b111000
    localparam logic [10:0] D_MATCH   = 11'h1C0;
    localparam logic [10:0] CB_MASK   = 11'h7F0;   // instr[31:25] == 7'b1011010
    localparam logic [10:0] CB_MATCH  = 11'h5A0;

    localparam logic [4:0]  XZR       = 5'd31;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        BR_FLUSH   = 2'd2
    } hz_state_t;

    function automatic logic op_match(input logic [10:0] op,
                                      input logic [10:0] mask,
                                      input logic [10:0] match);
        return (op & mask) == match;
    endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_decode.sv
// ============================================================================
// Module      : hazard_decode
// Description : Classifies one instruction (load / branch) and extracts the
//               register operands it reads.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_decode
    import cpu_pkg::*;
(
    input  logic [31:0] i_instr,
    output logic        o_is_load,
    output logic        o_is_branch,
    output logic [4:0]  o_src_a,
    output logic        o_src_a_vld,
    output logic [4:0]  o_src_b,
    output logic        o_src_b_vld,
    output logic [4:0]  o_rt
);

    logic [10:0] w_op;
    logic        w_rfmt;
    logic        w_dfmt;
    logic        w_cbfmt;
    logic        w_unused_bits;

    assign w_op        = i_instr[31:21];
    assign o_is_load   = (w_op == OP_LDUR);
    assign o_is_branch = op_match(w_op, BR_MASK, BR_MATCH);
    assign o_rt        = i_instr[4:0];

    // Branch encodings can alias the R-type pattern, so branches are excluded.
    assign w_rfmt  = !o_is_branch && op_match(w_op, R_MASK, R_MATCH);
    assign w_dfmt  = op_match(w_op, D_MASK, D_MATCH);
    assign w_cbfmt = op_match(w_op, CB_MASK, CB_MATCH);

    always_comb begin
        o_src_a     = i_instr[9:5];
        o_src_a_vld = 1'b0;
        o_src_b     = i_instr[20:16];
        o_src_b_vld = 1'b0;
        if (w_rfmt) begin
            o_src_a_vld = 1'b1;
            o_src_b_vld = 1'b1;
        end else if (w_dfmt) begin
            o_src_a_vld = 1'b1;
            if (w_op == OP_STUR) begin
                o_src_b     = i_instr[4:0];
                o_src_b_vld = 1'b1;
            end
        end else if (w_cbfmt) begin
            o_src_a     = i_instr[4:0];
            o_src_a_vld = 1'b1;
        end
    end

    assign w_unused_bits = &{1'b0, i_instr[15:10]};

endmodule

`default_nettype wire

// File: rtl/hazard_sched.sv
// ============================================================================
// Module      : hazard_sched
// Description : Load-use stall and branch-squash sequencer for the 5-stage
//               LEGv8 pipeline, with saturating hazard event counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_sched
    import cpu_pkg::*;
#(
    parameter int LOAD_STALL_CYC = 1,
    parameter int BR_FLUSH_CYC   = 1,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      id_instr,
    input  logic [31:0]      if_instr,
    input  logic             ext_stall,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             busy,
    output logic [CNT_W-1:0] load_stalls,
    output logic [CNT_W-1:0] br_flushes
);

    localparam logic [1:0] c_ld_init = 2'(LOAD_STALL_CYC - 1);
    localparam logic [1:0] c_br_init = 2'(BR_FLUSH_CYC - 1);

    hz_state_t        r_state;
    logic [1:0]       r_cnt;
    logic             r_busy;
    logic [CNT_W-1:0] r_load_stalls;
    logic [CNT_W-1:0] r_br_flushes;

    logic       w_id_load, w_id_branch;
    logic [4:0] w_id_rt;
    logic [4:0] w_id_src_a, w_id_src_b;
    logic       w_id_src_a_vld, w_id_src_b_vld;
    logic       w_if_load, w_if_branch;
    logic [4:0] w_if_rt;
    logic [4:0] w_if_src_a, w_if_src_b;
    logic       w_if_src_a_vld, w_if_src_b_vld;
    logic       w_unused_dec;

    hazard_decode u_dec_id (
        .i_instr     (id_instr),
        .o_is_load   (w_id_load),
        .o_is_branch (w_id_branch),
        .o_src_a     (w_id_src_a),
        .o_src_a_vld (w_id_src_a_vld),
        .o_src_b     (w_id_src_b),
        .o_src_b_vld (w_id_src_b_vld),
        .o_rt        (w_id_rt)
    );

    hazard_decode u_dec_if (
        .i_instr     (if_instr),
        .o_is_load   (w_if_load),
        .o_is_branch (w_if_branch),
        .o_src_a     (w_if_src_a),
        .o_src_a_vld (w_if_src_a_vld),
        .o_src_b     (w_if_src_b),
        .o_src_b_vld (w_if_src_b_vld),
        .o_rt        (w_if_rt)
    );

    assign w_unused_dec = &{1'b0, w_id_src_a, w_id_src_b, w_id_src_a_vld,
                            w_id_src_b_vld, w_if_load, w_if_branch, w_if_rt};

    logic w_hit;
    logic w_run;
    logic w_detect_ld;
    logic w_detect_br;
    logic w_ls_active;
    logic w_bf_active;

    assign w_hit = w_id_load && (w_id_rt != XZR) &&
                   ((w_if_src_a_vld && (w_if_src_a == w_id_rt)) ||
                    (w_if_src_b_vld && (w_if_src_b == w_id_rt)));

    assign w_run       = (r_state == RUN);
    assign w_detect_ld = !ext_stall && w_run && w_hit;
    assign w_detect_br = !ext_stall && w_run && !w_hit && w_id_branch;

    // The detection cycle is the first cycle of the event, so the state only
    // drives the controls while cycles remain; the cnt==0 cycle is the exit.
    assign w_ls_active = (r_state == LOAD_STALL) && (r_cnt != 2'd0);
    assign w_bf_active = (r_state == BR_FLUSH) && (r_cnt != 2'd0);

    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        if (reset) begin
            pc_en = 1'b1;
        end else if (ext_stall) begin
            pc_en   = 1'b0;
            ifid_en = 1'b0;
        end else if (w_detect_ld || w_ls_active) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_bubble = 1'b1;
        end else if (w_detect_br || w_bf_active) begin
            ifid_flush = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= RUN;
            r_cnt         <= 2'd0;
            r_busy        <= 1'b0;
            r_load_stalls <= '0;
            r_br_flushes  <= '0;
        end else if (!ext_stall) begin
            case (r_state)
                RUN: begin
                    if (w_hit) begin
                        r_state <= LOAD_STALL;
                        r_cnt   <= c_ld_init;
                        r_busy  <= 1'b1;
                        if (r_load_stalls != '1)
                            r_load_stalls <= r_load_stalls + CNT_W'(1);
                    end else if (w_id_branch) begin
                        r_state <= BR_FLUSH;
                        r_cnt   <= c_br_init;
                        r_busy  <= 1'b1;
                        if (r_br_flushes != '1)
                            r_br_flushes <= r_br_flushes + CNT_W'(1);
                    end
                end
                LOAD_STALL, BR_FLUSH: begin
                    if (r_cnt == 2'd0) begin
                        r_state <= RUN;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 2'd1;
                    end
                end
                default: begin
                    r_state <= RUN;
                    r_cnt   <= 2'd0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign load_stalls = r_load_stalls;
    assign br_flushes  = r_br_flushes;

endmodule

`default_nettype wire

// File: tb/tb_hazard_sched.sv
// ============================================================================
// Module      : tb_hazard_sched
// Description : Self-checking bench for hazard_sched, three parameter sets.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_hazard_sched;

    localparam int K_NOP = 0, K_LDUR = 1, K_STUR = 2, K_ADD = 3, K_SUB = 4;
    localparam int K_CBZ = 5, K_CBNZ = 6, K_B = 7, K_BL = 8, K_BCOND = 9;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] id_instr;
    logic [31:0] if_instr;
    logic        ext_stall;

    logic        pc_en_o     [3];
    logic        ifid_en_o   [3];
    logic        ifid_flush_o[3];
    logic        idex_bub_o  [3];
    logic        busy_o      [3];
    logic [15:0] ls_a, bf_a, ls_b, bf_b;
    logic [3:0]  ls_c, bf_c;

    int errors = 0;
    int checks = 0;

    int id_kind, id_rt, id_rn, id_rm;
    int if_kind, if_rd, if_rn, if_rm;

    int m_rem [3];
    int m_kind[3];
    int m_ls  [3];
    int m_bf  [3];

    always #5 clk = ~clk;

    hazard_sched #(.LOAD_STALL_CYC(1), .BR_FLUSH_CYC(2), .CNT_W(16)) u_dut_a (
        .clk(clk), .reset(reset), .id_instr(id_instr), .if_instr(if_instr),
        .ext_stall(ext_stall), .pc_en(pc_en_o[0]), .ifid_en(ifid_en_o[0]),
        .ifid_flush(ifid_flush_o[0]), .idex_bubble(idex_bub_o[0]),
        .busy(busy_o[0]), .load_stalls(ls_a), .br_flushes(bf_a));

    hazard_sched #(.LOAD_STALL_CYC(2), .BR_FLUSH_CYC(1), .CNT_W(16)) u_dut_b (
        .clk(clk), .reset(reset), .id_instr(id_instr), .if_instr(if_instr),
        .ext_stall(ext_stall), .pc_en(pc_en_o[1]), .ifid_en(ifid_en_o[1]),
        .ifid_flush(ifid_flush_o[1]), .idex_bubble(idex_bub_o[1]),
        .busy(busy_o[1]), .load_stalls(ls_b), .br_flushes(bf_b));

    hazard_sched #(.LOAD_STALL_CYC(3), .BR_FLUSH_CYC(3), .CNT_W(4)) u_dut_c (
        .clk(clk), .reset(reset), .id_instr(id_instr), .if_instr(if_instr),
        .ext_stall(ext_stall), .pc_en(pc_en_o[2]), .ifid_en(ifid_en_o[2]),
        .ifid_flush(ifid_flush_o[2]), .idex_bubble(idex_bub_o[2]),
        .busy(busy_o[2]), .load_stalls(ls_c), .br_flushes(bf_c));

    // {pc_en, ifid_en, ifid_flush, idex_bubble, busy}
    function automatic logic [4:0] ctl(input int k);
        return {pc_en_o[k], ifid_en_o[k], ifid_flush_o[k], idex_bub_o[k], busy_o[k]};
    endfunction

    function automatic int ls_of(input int k);
        return (k == 0) ? int'(ls_a) : (k == 1) ? int'(ls_b) : int'(ls_c);
    endfunction

    function automatic int bf_of(input int k);
        return (k == 0) ? int'(bf_a) : (k == 1) ? int'(bf_b) : int'(bf_c);
    endfunction

    function automatic int ld_cyc(input int k);  return k + 1; endfunction
    function automatic int br_cyc(input int k);  return (k == 0) ? 2 : (k == 1) ? 1 : 3; endfunction
    function automatic int cnt_max(input int k); return (k == 2) ? 15 : 65535; endfunction

    function automatic logic [31:0] mk(input int kind, input int rd, input int rn, input int rm);
        logic [4:0] d, n, m;
        d = rd[4:0];
        n = rn[4:0];
        m = rm[4:0];
        case (kind)
            K_LDUR:  return {11'h7C2, 9'd0, 2'd0, n, d};
            K_STUR:  return {11'h7C0, 9'd0, 2'd0, n, d};
            K_ADD:   return {11'h458, m, 6'd0, n, d};
            K_SUB:   return {11'h658, m, 6'd0, n, d};
            K_CBZ:   return {8'hB4, 19'd3, d};
            K_CBNZ:  return {8'hB5, 19'd3, d};
            K_B:     return {6'b000101, 26'd4};
            K_BL:    return {6'b100101, 26'd4};
            K_BCOND: return {8'h54, 19'd2, 1'b0, d[3:0]};
            default: return 32'h0;
        endcase
    endfunction

    // Registers an instruction of the given kind reads as a source.
    function automatic bit reads_reg(input int kind, input int rd, input int rn,
                                     input int rm, input int r);
        case (kind)
            K_ADD, K_SUB:  return (rn == r) || (rm == r);
            K_LDUR:        return rn == r;
            K_STUR:        return (rn == r) || (rd == r);
            K_CBZ, K_CBNZ: return rd == r;
            default:       return 1'b0;
        endcase
    endfunction

    function automatic bit is_branch_kind(input int kind);
        return kind inside {K_B, K_BL, K_CBZ, K_CBNZ, K_BCOND};
    endfunction

    function automatic int rand_reg();
        int v;
        v = $urandom_range(0, 3);
        return (v == 3) ? 31 : v + 1;
    endfunction

    task automatic do_reset();
        reset     = 1'b1;
        id_instr  = 32'h0;
        if_instr  = 32'h0;
        ext_stall = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            m_rem[k]  = 0;
            m_kind[k] = 0;
            m_ls[k]   = 0;
            m_bf[k]   = 0;
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        ext_stall = 1'b0;
        id_instr  = 32'hF8400041;
        if_instr  = 32'h8B040023;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (ctl(k) !== 5'b11000) begin
                errors++;
                $display("FAIL reset_ctl dut%0d: got %b want 11000", k, ctl(k));
            end
            checks++;
            if (ls_of(k) !== 0 || bf_of(k) !== 0) begin
                errors++;
                $display("FAIL reset_cnt dut%0d: got ls=%0d bf=%0d want 0/0", k, ls_of(k), bf_of(k));
            end
        end
        do_reset();
    endtask

    task automatic test_load_rn();
        do_reset();
        id_instr = 32'hF8400041;
        if_instr = 32'h8B040023;
        @(negedge clk);
        checks++;
        if (ctl(0) !== 5'b00010) begin
            errors++;
            $display("FAIL ld_detect: got %b want 00010", ctl(0));
        end
        next_cycle();
        id_instr = 32'h0;
        if_instr = 32'h0;
        @(negedge clk);
        checks++;
        if (ctl(0) !== 5'b11001) begin
            errors++;
            $display("FAIL ld_exit: got %b want 11001", ctl(0));
        end
        checks++;
        if (ls_a !== 16'd1) begin
            errors++;
            $display("FAIL ld_count: got %0d want 1", ls_a);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (ctl(0) !== 5'b11000) begin
            errors++;
            $display("FAIL ld_idle: got %b want 11000", ctl(0));
        end
    endtask

    task automatic test_xzr();
        do_reset();
        id_instr = 32'hF840005F;
        if_instr = 32'h8B1F03E3;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (ctl(k) !== 5'b11000) begin
                errors++;
                $display("FAIL xzr_ctl dut%0d: got %b want 11000", k, ctl(k));
            end
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (ctl(0) !== 5'b11000 || ls_a !== 16'd0) begin
            errors++;
            $display("FAIL xzr_after: got ctl=%b ls=%0d want 11000/0", ctl(0), ls_a);
        end
    endtask

    task automatic test_branch();
        do_reset();
        id_instr = 32'h14000004;
        if_instr = 32'h8B040023;
        @(negedge clk);
        checks++;
        if (ctl(0) !== 5'b11100 || ctl(1) !== 5'b11100) begin
            errors++;
            $display("FAIL br_detect: got a=%b b=%b want 11100", ctl(0), ctl(1));
        end
        next_cycle();
        id_instr = 32'h0;
        @(negedge clk);
        checks++;
        if (ctl(0) !== 5'b11101) begin
            errors++;
            $display("FAIL br_flush2: got %b want 11101", ctl(0));
        end
        checks++;
        if (ctl(1) !== 5'b11001) begin
            errors++;
            $display("FAIL br_flush1_exit: got %b want 11001", ctl(1));
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (ctl(0) !== 5'b11001) begin
            errors++;
            $display("FAIL br_exit: got %b want 11001", ctl(0));
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (ctl(0) !== 5'b11000 || bf_a !== 16'd1) begin
            errors++;
            $display("FAIL br_done: got ctl=%b bf=%0d want 11000/1", ctl(0), bf_a);
        end
    endtask

    task automatic test_load_cbz();
        logic [4:0] want[5];
        want = '{5'b00010, 5'b00011, 5'b11001, 5'b11100, 5'b11001};
        do_reset();
        id_instr = 32'hF8400041;
        if_instr = 32'hB4000021;
        for (int c = 0; c < 5; c++) begin
            if (c == 3) begin
                id_instr = 32'hB4000021;
                if_instr = 32'h0;
            end
            if (c == 4) id_instr = 32'h0;
            @(negedge clk);
            checks++;
            if (ctl(1) !== want[c]) begin
                errors++;
                $display("FAIL ldcbz_c%0d: got %b want %b", c, ctl(1), want[c]);
            end
            next_cycle();
        end
        checks++;
        if (ls_b !== 16'd1 || bf_b !== 16'd1) begin
            errors++;
            $display("FAIL ldcbz_cnt: got ls=%0d bf=%0d want 1/1", ls_b, bf_b);
        end
    endtask

    task automatic test_ext_stall();
        logic [4:0] want[8];
        want = '{5'b00010, 5'b00011, 5'b00001, 5'b00001, 5'b00001,
                 5'b00011, 5'b11001, 5'b11000};
        do_reset();
        id_instr = 32'hF8400041;
        if_instr = 32'h8B040023;
        for (int c = 0; c < 8; c++) begin
            ext_stall = (c >= 2 && c <= 4);
            if (c == 6) begin
                id_instr = 32'h0;
                if_instr = 32'h0;
            end
            @(negedge clk);
            checks++;
            if (ctl(2) !== want[c]) begin
                errors++;
                $display("FAIL ext_c%0d: got %b want %b", c, ctl(2), want[c]);
            end
            if (c == 3) begin
                checks++;
                if (ctl(0) !== 5'b00000) begin
                    errors++;
                    $display("FAIL ext_dut_a: got %b want 00000", ctl(0));
                end
            end
            next_cycle();
        end
        checks++;
        if (ls_c !== 4'd1) begin
            errors++;
            $display("FAIL ext_count: got %0d want 1", ls_c);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        id_instr = 32'h14000004;
        @(negedge clk);
        next_cycle();
        id_instr = 32'h0;
        #2 reset = 1'b1;
        #1;
        checks++;
        if (ctl(0) !== 5'b11000 || bf_a !== 16'd0) begin
            errors++;
            $display("FAIL rst_mid: got ctl=%b bf=%0d want 11000/0", ctl(0), bf_a);
        end
        next_cycle();
        reset = 1'b0;
    endtask

    task automatic test_saturation();
        do_reset();
        id_instr = 32'hF8400041;
        if_instr = 32'h8B040023;
        repeat (56) @(posedge clk);
        @(negedge clk);
        checks++;
        if (ls_c !== 4'd14 || ctl(2) !== 5'b00010) begin
            errors++;
            $display("FAIL sat_14: got ls=%0d ctl=%b want 14/00010", ls_c, ctl(2));
        end
        repeat (4) @(posedge clk);
        @(negedge clk);
        checks++;
        if (ls_c !== 4'd15) begin
            errors++;
            $display("FAIL sat_15: got %0d want 15", ls_c);
        end
        repeat (12) @(posedge clk);
        @(negedge clk);
        checks++;
        if (ls_c !== 4'd15) begin
            errors++;
            $display("FAIL sat_hold: got %0d want 15", ls_c);
        end
        next_cycle();
    endtask

    task automatic test_random();
        bit         hit, br;
        logic [4:0] e;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            id_kind = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 9) :
                      (($urandom_range(0, 1) == 0) ? K_LDUR : $urandom_range(0, 9));
            id_rt = rand_reg(); id_rn = rand_reg(); id_rm = rand_reg();
            if_kind = $urandom_range(0, 9);
            if_rd = rand_reg(); if_rn = rand_reg(); if_rm = rand_reg();
            id_instr  = mk(id_kind, id_rt, id_rn, id_rm);
            if_instr  = mk(if_kind, if_rd, if_rn, if_rm);
            ext_stall = ($urandom_range(0, 5) == 0);
            @(negedge clk);
            hit = (id_kind == K_LDUR) && (id_rt != 31) &&
                  reads_reg(if_kind, if_rd, if_rn, if_rm, id_rt);
            br  = is_branch_kind(id_kind);
            for (int k = 0; k < 3; k++) begin
                if (ext_stall)          e = {4'b0000, m_rem[k] > 0};
                else if (m_rem[k] == 0) e = hit ? 5'b00010 : br ? 5'b11100 : 5'b11000;
                else if (m_rem[k] > 1)  e = (m_kind[k] == 1) ? 5'b00011 : 5'b11101;
                else                    e = 5'b11001;
                checks++;
                if (ctl(k) !== e) begin
                    errors++;
                    $display("FAIL rnd_ctl dut%0d n=%0d: got %b want %b", k, n, ctl(k), e);
                end
                checks++;
                if (ls_of(k) !== m_ls[k] || bf_of(k) !== m_bf[k]) begin
                    errors++;
                    $display("FAIL rnd_cnt dut%0d n=%0d: got ls=%0d bf=%0d want %0d/%0d",
                             k, n, ls_of(k), bf_of(k), m_ls[k], m_bf[k]);
                end
                if (!ext_stall) begin
                    if (m_rem[k] == 0) begin
                        if (hit) begin
                            m_kind[k] = 1;
                            m_rem[k]  = ld_cyc(k);
                            if (m_ls[k] < cnt_max(k)) m_ls[k]++;
                        end else if (br) begin
                            m_kind[k] = 2;
                            m_rem[k]  = br_cyc(k);
                            if (m_bf[k] < cnt_max(k)) m_bf[k]++;
                        end
                    end else begin
                        m_rem[k]--;
                    end
                end
            end
            next_cycle();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within budget");
        $fatal(1, "timeout");
    end

    initial begin
        reset     = 1'b1;
        ext_stall = 1'b0;
        id_instr  = 32'h0;
        if_instr  = 32'h0;
        #1;
        test_reset();
        test_load_rn();
        test_xzr();
        test_branch();
        test_load_cbz();
        test_ext_stall();
        test_reset_mid();
        test_saturation();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
